// File: rtl/line_burst_bridge.sv
// Cache-line to narrow-bus burst bridge: one command beat, then BEATS data beats per line.
// Optional watchdog is built when BRIDGE_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for line_req; stray read beats are drained here
// CMD     | presenting the burst command
// WDATA   | streaming the captured line out, one beat per transfer
// RDATA   | gathering read beats into line_rdata
// ACK     | one-cycle line_ack pulse
// RELEASE | waiting for line_req to drop
module line_burst_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int BUS_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  input  logic                  line_we,
  input  logic                  line_req,
  output logic                  line_ack,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  cmd_we,
  output logic [7:0]            cmd_len,
  output logic                  wd_valid,
  input  logic                  wd_ready,
  output logic [BUS_WIDTH-1:0]  wd_data,
  output logic                  wd_last,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [BUS_WIDTH-1:0]  rd_data,
  input  logic                  rd_last,
  output logic [1:0]            err_status
);
  localparam int BEATS       = LINE_WIDTH / BUS_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LINE_WIDTH % BUS_WIDTH != 0 || TIMEOUT_CYCLES < 2 || OFFSET_BITS < 1) begin : g_bad_params
    $error("line_burst_bridge: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_RDATA, S_ACK, S_RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic                    err_proto_q;
  logic                    err_tmo;
  logic                    timeout;

  logic cmd_fire, wd_fire, rd_fire, last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign cmd_valid = (state_q == S_CMD);
  assign wd_valid  = (state_q == S_WDATA);
  assign rd_ready  = (state_q == S_IDLE) || (state_q == S_RDATA);
  assign line_ack  = (state_q == S_ACK);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wd_fire   = wd_valid && wd_ready;
  assign rd_fire   = rd_valid && rd_ready;

  // Payloads are gated so every output except rd_ready reads 0 out of reset.
  assign cmd_addr   = cmd_valid ? (addr_q & ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1)) : '0;
  assign cmd_we     = cmd_valid && we_q;
  assign cmd_len    = cmd_valid ? 8'(BEATS - 1) : 8'd0;
  assign wd_data    = wd_valid ? wdata_q[int'(cnt_q)*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign wd_last    = wd_valid && last_beat;
  assign line_rdata = rdata_q;
  assign err_status = {err_tmo, err_proto_q};

`ifdef BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog_q;
  logic            err_tmo_q;
  logic            active;

  assign active  = (state_q == S_CMD) || (state_q == S_WDATA) || (state_q == S_RDATA);
  assign timeout = active && (wdog_q == '0) && !(cmd_fire || wd_fire || (rd_fire && state_q == S_RDATA));
  assign err_tmo = err_tmo_q;

  // Down-counter reloads whenever a beat moves or the bridge is not mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= WD_W'(TIMEOUT_CYCLES - 1);
      err_tmo_q <= 1'b0;
    end else begin
      if (!active || cmd_fire || wd_fire || rd_fire)
        wdog_q <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (wdog_q != '0)
        wdog_q <= wdog_q - 1'b1;
      if (timeout)
        err_tmo_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (line_req) state_d = S_CMD;
      S_CMD:     if (cmd_fire) state_d = we_q ? S_WDATA : S_RDATA;
      S_WDATA:   if (wd_fire && last_beat) state_d = S_ACK;
      S_RDATA:   if (rd_fire && last_beat) state_d = S_ACK;
      S_ACK:     state_d = S_RELEASE;
      S_RELEASE: if (!line_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (timeout)
      state_d = S_ACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (line_req) begin
            addr_q  <= line_addr;
            we_q    <= line_we;
            wdata_q <= line_wdata;
          end
          if (rd_valid)
            err_proto_q <= 1'b1;
        end
        S_CMD: if (cmd_fire) cnt_q <= '0;
        S_WDATA: if (wd_fire && !last_beat) cnt_q <= cnt_q + 1'b1;
        S_RDATA: begin
          if (rd_fire) begin
            rdata_q[int'(cnt_q)*BUS_WIDTH +: BUS_WIDTH] <= rd_data;
            if (rd_last != last_beat)
              err_proto_q <= 1'b1;
            if (!last_beat)
              cnt_q <= cnt_q + 1'b1;
          end else if (timeout) begin
            // Beats never delivered read back as all-ones.
            for (int i = 0; i < BEATS; i++)
              if (i >= int'(cnt_q))
                rdata_q[i*BUS_WIDTH +: BUS_WIDTH] <= '1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_line_burst_bridge.sv
// Randomized and directed bench for line_burst_bridge against a line-level reference model.
module tb_line_burst_bridge;
  localparam int BEATS = 8;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  line_addr = '0;
  logic [511:0] line_wdata = '0;
  logic         line_we = 1'b0;
  logic         line_req = 1'b0;
  logic         line_ack;
  logic [511:0] line_rdata;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [31:0]  cmd_addr;
  logic         cmd_we;
  logic [7:0]   cmd_len;
  logic         wd_valid;
  logic         wd_ready = 1'b0;
  logic [63:0]  wd_data;
  logic         wd_last;
  logic         rd_valid = 1'b0;
  logic         rd_ready;
  logic [63:0]  rd_data = '0;
  logic         rd_last = 1'b0;
  logic [1:0]   err_status;

  line_burst_bridge #(.ADDR_WIDTH(32), .LINE_WIDTH(512), .BUS_WIDTH(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .line_addr(line_addr), .line_wdata(line_wdata), .line_we(line_we),
    .line_req(line_req), .line_ack(line_ack), .line_rdata(line_rdata), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_last(wd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .err_status(err_status)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [511:0] model_rdata = '0;
  logic [1:0]   model_err = '0;
  logic [63:0]  rd_beats [BEATS];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    line_req = 1'b0; cmd_ready = 1'b0; wd_ready = 1'b0;
    rd_valid = 1'b0; rd_last = 1'b0; rd_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {line_ack, cmd_valid, cmd_we, wd_valid, wd_last, rd_ready, err_status}, 8'b0000_0100);
    check({tag, "_pay"}, {cmd_addr, cmd_len, wd_data}, '0);
    check({tag, "_rdata"}, line_rdata, '0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_rdata = '0;
    model_err   = '0;
  endtask

  // mode: 0 zero-wait, 1 random gaps, 2 wd_ready toggling, 3 read data never arrives
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [511:0] wdata,
                         input int mode, input int cmd_stall, input int last_pos,
                         input int exp_lat, input int hold, input int rst_beat);
    int cyc = 1, wb = 0, k = 0;
    bit got_cmd = 0, acked = 0, cf, rf;
    logic [31:0] exp_addr = {addr[31:6], 6'b0};
    line_addr = addr; line_we = we; line_wdata = wdata; line_req = 1'b1;
    while (!acked && cyc < 400) begin
      cmd_ready = (cyc <= 1 + cmd_stall) ? 1'b0 : (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
      wd_ready  = (mode == 2) ? 1'(cyc % 2) : (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
      rd_valid  = got_cmd && !we && k < BEATS && mode != 3 && (mode != 1 || $urandom_range(0, 2) != 0);
      rd_data   = (k < BEATS) ? rd_beats[k] : '0;
      rd_last   = rd_valid && (k == last_pos);
      if (rst_beat >= 0 && wd_valid && wb == rst_beat) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid_write");
        idle_inputs();
        model_rdata = '0;
        model_err   = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (cmd_valid) check("cmd_addr", cmd_addr, exp_addr);
      cf = cmd_valid && cmd_ready;
      rf = rd_valid && rd_ready;
      if (cf) check("cmd_we_len", {cmd_we, cmd_len}, {we, 8'd7});
      if (wd_valid) begin
        check("wd_data", wd_data, wdata[wb*64 +: 64]);
        check("wd_last", wd_last, wb == BEATS - 1);
        if (wd_ready) wb++;
      end
      @(posedge clk); #1;
      cyc++;
      if (cf) got_cmd = 1;
      if (rf) k++;
      if (line_ack) acked = 1;
    end
    check("ack_seen", acked, 1'b1);
    if (exp_lat > 0) check("ack_latency", cyc, exp_lat);
    for (int j = 0; j < hold + 2; j++) begin
      line_req = (j < hold);
      rd_valid = 1'b0;
      @(posedge clk); #1;
      check("no_dup", {line_ack, cmd_valid}, 2'b00);
    end
    idle_inputs();
    if (we) check("wd_beats", wb, BEATS);
    else begin
      if (mode != 3) check("rd_beats", k, BEATS);
      for (int i = 0; i < BEATS; i++)
        model_rdata[i*64 +: 64] = (i < k) ? rd_beats[i] : '1;
      if (last_pos != BEATS - 1) model_err[0] = 1'b1;
      if (mode == 3) model_err[1] = 1'b1;
    end
    check("line_rdata", line_rdata, model_rdata);
    check("err_status", err_status, model_err);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic rand_beats();
    for (int i = 0; i < BEATS; i++) rd_beats[i] = {$urandom, $urandom};
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [511:0] wl;
    do_reset();
    rst_n = 1'b0; #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < BEATS; i++) rd_beats[i] = 64'h1111_0000_0000_0000 | 64'(i);
    run_txn(32'h0000_1040, 1'b0, '0, 0, 0, 7, 11, 0, -1);
    check("rdata_top_word", line_rdata[511:448], 64'h1111_0000_0000_0007);

    for (int i = 0; i < BEATS; i++) wl[i*64 +: 64] = 64'(i);
    run_txn(32'h0000_2000, 1'b1, wl, 2, 0, 7, -1, 0, -1);
    run_txn(32'h0000_30ff, 1'b0, '0, 0, 20, 7, 31, 2, -1);
    run_txn(32'hdead_beef, 1'b1, rand_line(), 0, 0, 7, 11, 1, -1);

    for (int t = 0; t < 12; t++) begin
      rand_beats();
      run_txn($urandom, 1'($urandom_range(0, 1)), rand_line(), 1, int'($urandom_range(0, 3)), 7, -1,
              int'($urandom_range(0, 3)), -1);
    end

    rand_beats();
    run_txn(32'h0000_4000, 1'b0, '0, 0, 0, 3, 11, 0, -1);

    do_reset();
    rand_beats();
    run_txn(32'h0000_5000, 1'b0, '0, 1, 0, -1, -1, 0, -1);

    do_reset();
    run_txn(32'h0000_6000, 1'b1, rand_line(), 0, 0, 7, -1, 0, 4);
    rand_beats();
    run_txn(32'h0000_7040, 1'b0, '0, 0, 0, 7, 11, 0, -1);

    rd_valid = 1'b1; rd_data = 64'h5a5a;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    model_err[0] = 1'b1;
    @(posedge clk); #1;
    check("stray_err", err_status, model_err);

`ifdef BRIDGE_TIMEOUT_EN
    do_reset();
    run_txn(32'h0000_8000, 1'b0, '0, 3, 0, 7, 19, 0, -1);
    check("tmo_rdata_ones", line_rdata, {512{1'b1}});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
